mult_unit: RTL

MULT_UNIT -- requirements
Module: mult_unit

---
 rtl/mult_unit_pkg.sv | 28 ++
 rtl/mult_pipe_reg.sv | 41 ++++
 rtl/mult_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mult_unit_pkg.sv
// Shared multiplier definitions: operation codes and decode helpers.
package mult_unit_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_MADD  = 3'd2,
    OP_MADDU = 3'd3,
    OP_MSUB  = 3'd4,
    OP_MSUBU = 3'd5
  } mul_op_t;

  // Undefined codes fall through all helpers as false, i.e. behave as MULTU.
  function automatic logic is_signed(input mul_op_t op);
    return op inside {OP_MULT, OP_MADD, OP_MSUB};
  endfunction

  function automatic logic is_acc(input mul_op_t op);
    return op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  endfunction

  function automatic logic is_sub(input mul_op_t op);
    return op inside {OP_MSUB, OP_MSUBU};
  endfunction

endpackage

// File: rtl/mult_pipe_reg.sv
// One pipeline stage: valid bit plus payload, with stall enable and flush.
module mult_pipe_reg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Flush only kills the valid bit; payload is don't-care once invalid.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (!resetn) begin
      valid_d = 1'b0;
      data_d  = '0;
    end else if (flush) begin
      valid_d = 1'b0;
    end else if (en) begin
      valid_d = in_valid;
      data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    data_q  <= data_d;
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/mult_unit.sv
// Pipelined signed/unsigned multiplier with multiply-add/subtract and a
// global-stall valid/ready handshake.
module mult_unit
  import mult_unit_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);

  localparam int unsigned HALF   = WIDTH / 2;
  localparam int unsigned DW     = 2 * WIDTH;
  localparam int unsigned PP_W   = 4 * WIDTH;
  localparam int unsigned CORR_W = WIDTH + 1;
  localparam int unsigned S1_W   = PP_W + CORR_W + DW + OP_W + TAG_W;
  localparam int unsigned RES_W  = DW + TAG_W;

  if (WIDTH < 8 || WIDTH > 64 || (WIDTH % 2) != 0 || STAGES < 1 || STAGES > 4) begin : g_param_check
    $error("mult_unit: illegal WIDTH=%0d or STAGES=%0d", WIDTH, STAGES);
  end

  // Unsigned half-width partial products, packed {hh, hl, lh, ll}.
  function automatic logic [PP_W-1:0] partials(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] xl, xh, yl, yh;
    xl = WIDTH'(x[HALF-1:0]);
    xh = WIDTH'(x[WIDTH-1:HALF]);
    yl = WIDTH'(y[HALF-1:0]);
    yh = WIDTH'(y[WIDTH-1:HALF]);
    return {xh * yh, xh * yl, xl * yh, xl * yl};
  endfunction

  // Sign-extension turns ext(x)*ext(y) into x*y minus these terms at 2^WIDTH.
  function automatic logic [CORR_W-1:0] sign_corr(input mul_op_t o, input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
    logic [CORR_W-1:0] c;
    c = '0;
    if (is_signed(o) && x[WIDTH-1]) c = c + CORR_W'(y);
    if (is_signed(o) && y[WIDTH-1]) c = c + CORR_W'(x);
    return c;
  endfunction

  function automatic logic [DW-1:0] combine(input logic [PP_W-1:0] pp, input logic [CORR_W-1:0] c,
                                            input logic [DW-1:0] acc_v, input mul_op_t o);
    logic [DW-1:0] p;
    p = DW'(pp[WIDTH-1:0])
      + (DW'(pp[2*WIDTH-1:WIDTH]) << HALF)
      + (DW'(pp[3*WIDTH-1:2*WIDTH]) << HALF)
      + (DW'(pp[4*WIDTH-1:3*WIDTH]) << WIDTH)
      - (DW'(c) << WIDTH);
    if (!is_acc(o)) return p;
    if (is_sub(o)) return acc_v - p;
    return acc_v + p;
  endfunction

  mul_op_t          op_in_c;
  logic             advance_c;
  logic             last_valid;
  logic [RES_W-1:0] last_data;

  assign op_in_c   = mul_op_t'(op);
  assign advance_c = !out_valid || out_ready;
  assign in_ready  = advance_c;
  assign out_valid = last_valid;
  assign result    = last_data[RES_W-1:TAG_W];
  assign out_tag   = last_data[TAG_W-1:0];

  if (STAGES == 1) begin : g_single
    logic [RES_W-1:0] res_in_c;
    assign res_in_c = {combine(partials(a, b), sign_corr(op_in_c, a, b), acc, op_in_c), in_tag};

    mult_pipe_reg #(.DATA_W(RES_W)) u_stage (
      .clk(clk), .resetn(resetn), .en(advance_c), .flush(flush),
      .in_valid(in_valid), .in_data(res_in_c),
      .out_valid(last_valid), .out_data(last_data)
    );
    assign busy = last_valid;
  end else begin : g_multi
    logic              s1_valid;
    logic [S1_W-1:0]   s1_in_c, s1_data;
    logic [PP_W-1:0]   s1_pp;
    logic [CORR_W-1:0] s1_corr;
    logic [DW-1:0]     s1_acc;
    mul_op_t           s1_op;
    logic [TAG_W-1:0]  s1_tag;
    logic [STAGES-2:0] rv;
    logic [RES_W-1:0]  rd [STAGES-1];

    // Stage 1 captures partial products with the op, acc and tag they belong to.
    assign s1_in_c = {partials(a, b), sign_corr(op_in_c, a, b), acc, op, in_tag};

    mult_pipe_reg #(.DATA_W(S1_W)) u_stage1 (
      .clk(clk), .resetn(resetn), .en(advance_c), .flush(flush),
      .in_valid(in_valid), .in_data(s1_in_c),
      .out_valid(s1_valid), .out_data(s1_data)
    );

    assign s1_pp   = s1_data[S1_W-1 -: PP_W];
    assign s1_corr = s1_data[S1_W-PP_W-1 -: CORR_W];
    assign s1_acc  = s1_data[TAG_W+OP_W +: DW];
    assign s1_op   = mul_op_t'(s1_data[TAG_W +: OP_W]);
    assign s1_tag  = s1_data[TAG_W-1:0];

    for (genvar k = 0; k < STAGES - 1; k++) begin : g_res
      logic             vin;
      logic [RES_W-1:0] din;
      if (k == 0) begin : g_first
        assign vin = s1_valid;
        assign din = {combine(s1_pp, s1_corr, s1_acc, s1_op), s1_tag};
      end else begin : g_next
        assign vin = rv[k-1];
        assign din = rd[k-1];
      end

      mult_pipe_reg #(.DATA_W(RES_W)) u_stage (
        .clk(clk), .resetn(resetn), .en(advance_c), .flush(flush),
        .in_valid(vin), .in_data(din),
        .out_valid(rv[k]), .out_data(rd[k])
      );
    end

    assign last_valid = rv[STAGES-2];
    assign last_data  = rd[STAGES-2];
    assign busy       = s1_valid | (|rv);
  end

endmodule
